// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the unified memory port arbiter.
//   arb_state_e  : arbiter FSM states (IDLE, DATA_BUSY, FETCH_BUSY)
//   DEF_ADDR_W   : default memory address width
//   DEF_DATA_W   : default memory data width
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA_BUSY  = 2'd1,
        FETCH_BUSY = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the CPU's single memory port between instruction fetch and the
// MEM-stage data access. Data access has fixed priority. Drives a
// variable-latency req/ack handshake and generates pipeline freeze signals
// while a requester waits on the port.
//
// Ports:
//   clk, rest                  clock, synchronous active-high reset
//   if_req/if_addr             fetch request and PC
//   if_rdata/if_valid          fetched instruction, one-cycle valid pulse
//   dm_read/dm_write           load / store request (both = store)
//   dm_addr/dm_wdata           data address / store data
//   dm_rdata/dm_valid          load data, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until mem_ack
//   mem_ack/mem_rdata          memory completion, read data valid with ack
//   freeze_pc/freeze_ifid/freeze_pipe  pipeline hold signals
//   stall_cycles               saturating count of data-stall cycles
//
// Build option:
//   MEMARB_STALL_CNT_EN  when defined, stall_cycles counts cycles with
//                        freeze_pipe high (saturating at 16'hFFFF);
//                        otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rest,
    // instruction fetch
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    // data access
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    // memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    // pipeline control
    output logic              freeze_pc,
    output logic              freeze_ifid,
    output logic              freeze_pipe,
    output logic [15:0]       stall_cycles
);

    arb_state_e          state_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic                if_valid_q;
    logic [DATA_W-1:0]   dm_rdata_q;
    logic                dm_valid_q;

    // A requester is pending while it asserts its request and has not just
    // been served. The valid pulse masks the request for exactly the cycle
    // in which the pipeline advances, so a held request is not re-granted.
    logic data_pending;
    logic fetch_pending;

    assign data_pending  = (dm_read | dm_write) & ~dm_valid_q;
    assign fetch_pending = if_req & ~if_valid_q;

    assign freeze_pipe = data_pending;
    assign freeze_pc   = data_pending | fetch_pending;
    assign freeze_ifid = data_pending | fetch_pending;

    // -------------------------------------------------------------------------
    // Arbiter FSM with registered memory-side and response outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rest) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
        end else begin
            // valid outputs are single-cycle pulses
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // mem_ack seen here is stale and deliberately ignored
                    if (data_pending) begin
                        state_q     <= DATA_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_write;   // read+write counts as write
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                    end else if (fetch_pending) begin
                        state_q    <= FETCH_BUSY;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr;
                    end
                end

                DATA_BUSY: begin
                    if (mem_ack) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        dm_valid_q <= 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_q <= mem_rdata;
                        end
                    end
                end

                FETCH_BUSY: begin
                    if (mem_ack) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        if_valid_q <= 1'b1;
                        if_rdata_q <= mem_rdata;
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;

    // -------------------------------------------------------------------------
    // Data-stall cycle counter
    // -------------------------------------------------------------------------
`ifdef MEMARB_STALL_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (freeze_pipe && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule : mem_port_arbiter
